// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline sequencing controller.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_W_DEF = 4;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned INSTR_W   = 16;

  localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: ID-stage sources against the EX-stage load destination.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_valid,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_valid,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  output logic             hazard
);

  assign hazard = ex_is_load &
                  ((id_rs_valid & (id_rs == ex_rd)) |
                   (id_rt_valid & (id_rt == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Shared memory-port arbiter and freeze/flush/bubble generator for the pipeline.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             halt,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_valid,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_valid,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_is_mem,
  input  logic             mem_is_mem,
  input  logic             mem_is_write,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_we,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             back_freeze,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t state;
  state_t state_next;
  logic   advance;
  logic   hazard;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_rs       (id_rs),
    .id_rs_valid (id_rs_valid),
    .id_rt       (id_rt),
    .id_rt_valid (id_rt_valid),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .hazard      (hazard)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Only a completed fetch moves the pipeline; data completion always hands over to the fetch.
  always_comb begin
    state_next = state;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (!halt) state_next = mem_is_mem ? BUSY_D : BUSY_IF;
      end
      BUSY_D: begin
        if (mem_ready) state_next = BUSY_IF;
      end
      BUSY_IF: begin
        if (mem_ready) begin
          advance = 1'b1;
          if (halt)           state_next = IDLE;
          else if (ex_is_mem) state_next = BUSY_D;
          else                state_next = BUSY_IF;
        end
      end
      default: state_next = IDLE;
    endcase

    mem_req      = (state != IDLE);
    mem_sel      = (state == BUSY_D);
    mem_we       = (state == BUSY_D) & mem_is_write;
    back_freeze  = ~advance;
    pc_freeze    = ~advance | hazard;
    if_id_freeze = ~advance | hazard;
    id_ex_bubble = advance & hazard;
    if_id_flush  = advance & branch_taken & ~hazard;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (back_freeze && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: access-level reference model, directed plus random stimulus.
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_W = 4;
  localparam int unsigned CNT_W = 16;

  typedef struct packed {
    logic             rst;
    logic             halt;
    logic [REG_W-1:0] rs;
    logic             rsv;
    logic [REG_W-1:0] rt;
    logic             rtv;
    logic [REG_W-1:0] ex_rd;
    logic             ex_load;
    logic             ex_mem;
    logic             mem_mem;
    logic             mem_wr;
    logic             br;
    logic             ready;
  } stim_t;

  typedef enum int {ACC_NONE, ACC_FETCH, ACC_DATA} access_t;

  logic             CLK = 1'b0;
  logic             RST;
  logic             halt, id_rs_valid, id_rt_valid, ex_is_load, ex_is_mem;
  logic             mem_is_mem, mem_is_write, branch_taken, mem_ready;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             mem_req, mem_sel, mem_we, pc_freeze, if_id_freeze;
  logic             if_id_flush, id_ex_bubble, back_freeze;
  logic [CNT_W-1:0] stall_cnt;

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .halt(halt),
    .id_rs(id_rs), .id_rs_valid(id_rs_valid), .id_rt(id_rt), .id_rt_valid(id_rt_valid),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_is_mem(ex_is_mem),
    .mem_is_mem(mem_is_mem), .mem_is_write(mem_is_write),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we),
    .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .back_freeze(back_freeze), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  int unsigned    vectors = 0;
  int unsigned    errors  = 0;
  logic [23:0]    sb_q[$];
  access_t        acc = ACC_NONE;
  int unsigned    cnt_model = 0;
  bit             last_backf = 1'b1;
  bit             quiet = 1'b0;
  stim_t          cur;

  // Expected outputs from what the memory port is currently doing and this cycle's inputs.
  function automatic logic [23:0] expect_out(stim_t s);
    bit hz, adv;
    hz  = s.ex_load && ((s.rsv && s.rs == s.ex_rd) || (s.rtv && s.rt == s.ex_rd));
    adv = (acc == ACC_FETCH) && s.ready;
    return {acc != ACC_NONE, acc == ACC_DATA, (acc == ACC_DATA) && s.mem_wr,
            !adv || hz, !adv || hz, adv && s.br && !hz, adv && hz, !adv,
            16'(cnt_model)};
  endfunction

  task automatic apply(input stim_t s);
    RST = s.rst; halt = s.halt;
    id_rs = s.rs; id_rs_valid = s.rsv; id_rt = s.rt; id_rt_valid = s.rtv;
    ex_rd = s.ex_rd; ex_is_load = s.ex_load; ex_is_mem = s.ex_mem;
    mem_is_mem = s.mem_mem; mem_is_write = s.mem_wr;
    branch_taken = s.br; mem_ready = s.ready;
  endtask

  // One clock: advance the model over the edge, then drive and predict the new cycle.
  task automatic step(input stim_t s);
    logic [23:0] e;
    @(posedge CLK);
    if (!cur.rst) begin
      if (last_backf && cnt_model < 65535) cnt_model++;
      case (acc)
        ACC_NONE:  if (!cur.halt) acc = cur.mem_mem ? ACC_DATA : ACC_FETCH;
        ACC_DATA:  if (cur.ready) acc = ACC_FETCH;
        ACC_FETCH: if (cur.ready) acc = cur.halt ? ACC_NONE : (cur.ex_mem ? ACC_DATA : ACC_FETCH);
        default:   acc = ACC_NONE;
      endcase
    end
    #1;
    cur = s;
    apply(s);
    if (s.rst) begin
      acc = ACC_NONE;
      cnt_model = 0;
    end
    e = expect_out(s);
    last_backf = e[16];
    if (!quiet) sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare presented outputs mid-cycle against the queued prediction.
  always @(negedge CLK) begin
    logic [23:0] act, exp;
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      act = {mem_req, mem_sel, mem_we, pc_freeze, if_id_freeze, if_id_flush,
             id_ex_bubble, back_freeze, stall_cnt};
      vectors++;
      if (act !== exp) begin
        errors++;
        $display("FAIL scoreboard t=%0t {req,sel,we,pcf,iff,flush,bub,backf}: got %b cnt %h, expected %b cnt %h",
                 $time, act[23:16], act[15:0], exp[23:16], exp[15:0]);
      end
    end
  end

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  initial begin
    stim_t s;
    cur = idle_stim();
    cur.rst = 1'b1;
    apply(cur);

    // Reset state and reset mid-data-access.
    s = idle_stim(); s.rst = 1'b1;
    step(s);
    #1 chk("reset_pc_freeze", 16'(pc_freeze), 16'd1);
    chk("reset_mem_req", 16'(mem_req), 16'd0);
    s = idle_stim(); s.mem_mem = 1'b1;
    step(s);
    #1 chk("first_cycle_idle", 16'(mem_req), 16'd0);
    step(s);
    #1 chk("data_access_sel", 16'(mem_sel), 16'd1);
    s.rst = 1'b1;
    step(s);
    #1 chk("reset_mid_data_req", 16'(mem_req), 16'd0);
    chk("reset_mid_data_cnt", stall_cnt, 16'd0);
    s = idle_stim();
    step(s);
    step(s);
    #1 chk("fetch_after_release", {15'd0, mem_req}, 16'd1);

    // Zero-wait stream: pipeline advances every cycle.
    s.ready = 1'b1;
    repeat (4) step(s);
    #1 chk("zero_wait_pc_freeze", 16'(pc_freeze), 16'd0);

    // Load-use hazard at advance, then clean advance.
    s.ex_load = 1'b1; s.ex_rd = 4'd3; s.rs = 4'd3; s.rsv = 1'b1;
    step(s);
    #1 chk("hazard_bubble", 16'({pc_freeze, if_id_freeze, id_ex_bubble, back_freeze}), 16'b1110);
    s.br = 1'b1;
    step(s);
    #1 chk("hazard_hides_branch", 16'({if_id_flush, id_ex_bubble}), 16'b01);
    s.ex_load = 1'b0;
    step(s);
    #1 chk("branch_flush", 16'(if_id_flush), 16'd1);
    s.br = 1'b0;
    step(s);
    #1 chk("flush_one_cycle", 16'(if_id_flush), 16'd0);

    // Store entering MEM takes a data slot before the next fetch.
    s.ex_mem = 1'b1; s.mem_wr = 1'b1;
    step(s);
    s.ex_mem = 1'b0;
    step(s);
    #1 chk("store_slot", 16'({mem_sel, mem_we, back_freeze}), 16'b111);
    step(s);
    #1 chk("fetch_after_store", 16'({mem_sel, back_freeze}), 16'b00);

    // Halt waits for the in-flight fetch, then parks in IDLE.
    s = idle_stim(); s.halt = 1'b1;
    repeat (3) step(s);
    #1 chk("halt_waits_ready", 16'(mem_req), 16'd1);
    s.ready = 1'b1;
    step(s);
    s.ready = 1'b0;
    step(s);
    #1 chk("halt_idle", 16'(mem_req), 16'd0);
    s.halt = 1'b0;
    step(s);
    step(s);
    #1 chk("resume_fetch", 16'({mem_req, mem_sel}), 16'b10);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      s.rst     = ($urandom_range(0, 63) == 0);
      s.halt    = ($urandom_range(0, 7) == 0);
      s.rs      = REG_W'($urandom_range(0, 3));
      s.rt      = REG_W'($urandom_range(0, 3));
      s.ex_rd   = REG_W'($urandom_range(0, 3));
      s.rsv     = 1'($urandom);
      s.rtv     = 1'($urandom);
      s.ex_load = 1'($urandom);
      s.ex_mem  = ($urandom_range(0, 2) == 0);
      s.mem_mem = ($urandom_range(0, 2) == 0);
      s.mem_wr  = 1'($urandom);
      s.br      = ($urandom_range(0, 3) == 0);
      s.ready   = ($urandom_range(0, 3) != 0);
      step(s);
    end

    // Saturation: long halt keeps back_freeze high.
    s = idle_stim(); s.rst = 1'b1;
    step(s);
    s = idle_stim(); s.halt = 1'b1;
    quiet = 1'b1;
    repeat (65540) step(s);
    quiet = 1'b0;
    step(s);
    #1 chk("stall_cnt_saturated", stall_cnt, 16'hFFFF);
    step(s);

    repeat (2) @(negedge CLK);
    if (sb_q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
